// File: rtl/game_pkg.sv
// Shared game-level types: game state, update stage indices and scheduler FSM states.
package game_pkg;

    typedef enum logic [1:0] {
        GS_START   = 2'd0,
        GS_RUNNING = 2'd1,
        GS_OVER    = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        STG_PHYSICS = 2'd0,
        STG_COLLIDE = 2'd1,
        STG_SCROLL  = 2'd2,
        STG_SCORE   = 2'd3
    } stage_id_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        START,
        WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/stage_timer.sv
// Saturating watchdog for one outstanding update stage; expired flags TIMEOUT_CYCLES-1.
module stage_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/update_scheduler.sv
// Runs the per-step update stages in order during vblank, one start/done handshake at a time.
// Optional UPDATE_SCHEDULER_STATS_EN adds saturating overrun/timeout counters.
module update_scheduler
    import game_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int STEP_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  vblank,
    input  logic [1:0]            game_state,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout,
`ifdef UPDATE_SCHEDULER_STATS_EN
    output logic [7:0]            overrun_cnt,
    output logic [7:0]            timeout_cnt,
`endif
    output logic [STEP_W-1:0]     step_count
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(STG_PHYSICS);

    sched_state_t   state;
    logic [IDX_W-1:0] idx;
    logic           running;
    logic           timer_clear;
    logic           timer_expired;

    assign running = (game_state == GS_RUNNING);

    // The timer is held at zero until the start pulse so it counts cycles since the pulse.
    assign timer_clear = !((state == WAIT_DONE) || (state == START && stage_start != '0));

    stage_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stage_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (state == START || state == WAIT_DONE),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            stage_start <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
            step_count  <= '0;
        end else begin
            stage_start <= '0;
            overrun     <= tick && (state != IDLE);
            timeout     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && running) begin
                        state <= WAIT_VB;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VB: begin
                    if (!running) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vblank) begin
                        state       <= START;
                        idx         <= FIRST_IDX;
                        stage_start <= NUM_STAGES'(1) << FIRST_IDX;
                    end
                end
                // Stage 0 arrives with its pulse already set; later stages spend one gap cycle here first.
                START: begin
                    if (stage_start != '0) begin
                        state <= WAIT_DONE;
                    end else if (!running) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        stage_start <= NUM_STAGES'(1) << idx;
                    end
                end
                WAIT_DONE: begin
                    if (stage_done[idx]) begin
                        if (idx == LAST_IDX || !running) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (idx == LAST_IDX) begin
                                step_count <= step_count + 1'b1;
                            end
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= START;
                        end
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UPDATE_SCHEDULER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            if (overrun && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
            if (timeout && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
